// File: rtl/riscv_hwloop_jump_ctrl_pkg.sv
// Shared definitions for the hardware-loop jump controller slice.
//   HWLP_N_REGS        : default number of hardware-loop register sets
//   hwlp_addr_t        : 32-bit instruction address
//   hwlp_ctrl_state_e  : controller state (IDLE, JMP_DEC, JMP, DEC)
package riscv_hwloop_pkg;

    localparam int HWLP_N_REGS = 2;

    typedef logic [31:0] hwlp_addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        JMP_DEC = 2'd1,
        JMP     = 2'd2,
        DEC     = 2'd3
    } hwlp_ctrl_state_e;

endpackage

// File: rtl/riscv_hwloop_jump_ctrl_if.sv
// Redirect / decrement handshake bundle between the jump controller and its
// neighbours (prefetch unit for the redirect, ID stage / loop registers for
// the decrement commit).
//   hwlp_jump       : redirect request to prefetch
//   hwlp_targ_addr  : redirect target address
//   jump_ack        : prefetch accepted the redirect
//   hwlp_dec_cnt    : one-hot decrement request to the loop registers
//   id_valid        : the loop-end instruction leaves ID this cycle
// master = controller side, slave = prefetch / ID / loop-register side.
interface riscv_hwloop_jump_ctrl_if #(
    parameter int N_REGS = riscv_hwloop_pkg::HWLP_N_REGS
);
    logic                         hwlp_jump;
    riscv_hwloop_pkg::hwlp_addr_t hwlp_targ_addr;
    logic                         jump_ack;
    logic [N_REGS-1:0]            hwlp_dec_cnt;
    logic                         id_valid;

    modport master (
        output hwlp_jump,
        output hwlp_targ_addr,
        output hwlp_dec_cnt,
        input  jump_ack,
        input  id_valid
    );

    modport slave (
        input  hwlp_jump,
        input  hwlp_targ_addr,
        input  hwlp_dec_cnt,
        output jump_ack,
        output id_valid
    );
endinterface

// File: rtl/riscv_hwloop_jump_ctrl_match.sv
// Per-loop end-address compare and priority encoder.
//   fetch_addr_i      : address being issued from fetch
//   hwlp_end_addr_i   : per-loop end addresses
//   hwlp_counter_i    : per-loop counters (0 = loop inactive)
//   match_o           : raw per-loop match vector
//   owner_valid_o     : at least one loop matches
//   owner_onehot_o    : one-hot of the lowest matching loop
//   owner_idx_o       : index of the lowest matching loop
//   owner_cnt_gt1_o   : owner's counter is above 1 (loop jumps back)
module riscv_hwloop_match
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = HWLP_N_REGS,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  hwlp_addr_t                   fetch_addr_i,
    input  logic [N_REGS-1:0][31:0]      hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0]      hwlp_counter_i,
    output logic [N_REGS-1:0]            match_o,
    output logic                         owner_valid_o,
    output logic [N_REGS-1:0]            owner_onehot_o,
    output logic [N_REG_BITS-1:0]        owner_idx_o,
    output logic                         owner_cnt_gt1_o
);

    // A zero counter marks an inactive loop, so it can never claim a fetch.
    generate
        for (genvar gi = 0; gi < N_REGS; gi++) begin : g_match
            assign match_o[gi] = (fetch_addr_i == hwlp_end_addr_i[gi]) &&
                                 (hwlp_counter_i[gi] != 32'd0);
        end
    endgenerate

    // Scan from the outermost loop down so the innermost (lowest index) wins.
    always_comb begin
        owner_idx_o = '0;
        for (int k = N_REGS - 1; k >= 0; k--) begin
            if (match_o[k]) begin
                owner_idx_o = N_REG_BITS'(k);
            end
        end
    end

    assign owner_valid_o = |match_o;

    always_comb begin
        owner_onehot_o              = '0;
        owner_onehot_o[owner_idx_o] = owner_valid_o;
    end

    assign owner_cnt_gt1_o = owner_valid_o && (hwlp_counter_i[owner_idx_o] > 32'd1);

endmodule

// File: rtl/riscv_hwloop_jump_ctrl.sv
// Hardware-loop jump controller: consumer side of the loop register file.
// Watches the fetch stream for a loop end address; when it hits an active
// loop it requests a redirect to the loop start (unless this is the last
// iteration) and a one-hot decrement of that loop's counter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   fetch_addr_i/valid_i: instruction handed from fetch to ID this cycle
//   flush_i             : pipeline flush, cancels pending requests
//   hwlp_start/end_addr_i, hwlp_counter_i : loop register contents
//   hwlp_if (master)    : redirect + decrement handshake
//   hwlp_busy_o         : a request is pending, detection is blocked
module riscv_hwloop_jump_ctrl
    import riscv_hwloop_pkg::*;
#(
    parameter int N_REGS     = HWLP_N_REGS,
    parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  hwlp_addr_t               fetch_addr_i,
    input  logic                     fetch_valid_i,
    input  logic                     flush_i,
    input  logic [N_REGS-1:0][31:0]  hwlp_start_addr_i,
    input  logic [N_REGS-1:0][31:0]  hwlp_end_addr_i,
    input  logic [N_REGS-1:0][31:0]  hwlp_counter_i,
    riscv_hwloop_jump_ctrl_if.master hwlp_if,
    output logic                     hwlp_busy_o
);

    hwlp_ctrl_state_e        state_reg, state_next;
    logic [N_REGS-1:0]       dec_reg, dec_next;
    hwlp_addr_t              targ_reg, targ_next;
    logic                    jump_reg, jump_next;

    logic [N_REGS-1:0]       match_vec;
    logic                    owner_valid;
    logic [N_REGS-1:0]       owner_onehot;
    logic [N_REG_BITS-1:0]   owner_idx;
    logic                    owner_cnt_gt1;

    riscv_hwloop_match #(
        .N_REGS     (N_REGS),
        .N_REG_BITS (N_REG_BITS)
    ) u_match (
        .fetch_addr_i    (fetch_addr_i),
        .hwlp_end_addr_i (hwlp_end_addr_i),
        .hwlp_counter_i  (hwlp_counter_i),
        .match_o         (match_vec),
        .owner_valid_o   (owner_valid),
        .owner_onehot_o  (owner_onehot),
        .owner_idx_o     (owner_idx),
        .owner_cnt_gt1_o (owner_cnt_gt1)
    );

    always_comb begin
        state_next = state_reg;
        dec_next   = dec_reg;
        targ_next  = targ_reg;

        if (flush_i) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (fetch_valid_i && owner_valid) begin
                        dec_next = owner_onehot;
                        if (owner_cnt_gt1) begin
                            targ_next  = hwlp_start_addr_i[owner_idx];
                            state_next = JMP_DEC;
                        end else begin
                            // Last iteration falls through: decrement only.
                            state_next = DEC;
                        end
                    end
                end
                JMP_DEC: begin
                    if (hwlp_if.jump_ack && hwlp_if.id_valid) state_next = IDLE;
                    else if (hwlp_if.jump_ack)                state_next = DEC;
                    else if (hwlp_if.id_valid)                state_next = JMP;
                end
                JMP: if (hwlp_if.jump_ack) state_next = IDLE;
                DEC: if (hwlp_if.id_valid) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        // Output flags are precomputed from the next state so that both
        // requests come straight out of flops.
        if (!(state_next == JMP_DEC || state_next == DEC)) begin
            dec_next = '0;
        end
        jump_next = (state_next == JMP_DEC) || (state_next == JMP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            dec_reg   <= '0;
            targ_reg  <= '0;
            jump_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dec_reg   <= dec_next;
            targ_reg  <= targ_next;
            jump_reg  <= jump_next;
        end
    end

    assign hwlp_if.hwlp_jump      = jump_reg;
    assign hwlp_if.hwlp_targ_addr = targ_reg;
    assign hwlp_if.hwlp_dec_cnt   = dec_reg;
    assign hwlp_busy_o            = (state_reg != IDLE);

`ifndef SYNTHESIS
    a_dec_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(dec_reg));

    a_jump_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (jump_reg && !hwlp_if.jump_ack && !flush_i) |=> (jump_reg && $stable(targ_reg)));

    // Loops sharing an active end address are a software error.
    a_single_match : assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == IDLE && fetch_valid_i && !flush_i) |-> $onehot0(match_vec));
`endif

endmodule

// File: tb/tb_riscv_hwloop_jump_ctrl.sv
module tb_riscv_hwloop_jump_ctrl;
    import riscv_hwloop_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hwlp_addr_t          fetch_addr;
    logic                fetch_valid;
    logic                flush;
    logic [1:0][31:0]    start_a;
    logic [1:0][31:0]    end_a;
    logic [1:0][31:0]    cnt;
    logic                busy;

    riscv_hwloop_jump_ctrl_if #(.N_REGS(2)) hif ();

    riscv_hwloop_jump_ctrl #(.N_REGS(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_addr_i      (fetch_addr),
        .fetch_valid_i     (fetch_valid),
        .flush_i           (flush),
        .hwlp_start_addr_i (start_a),
        .hwlp_end_addr_i   (end_a),
        .hwlp_counter_i    (cnt),
        .hwlp_if           (hif),
        .hwlp_busy_o       (busy)
    );

    typedef struct packed {
        logic        jump;
        logic [31:0] targ;
        logic [1:0]  dec;
        logic        busy;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;
    int    dec_events = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input string tag, input logic j, input logic [31:0] t,
                        input logic [1:0] d, input logic b);
        exp_t e;
        e.jump = j; e.targ = t; e.dec = d; e.busy = b;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string tag;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e   = exp_q.pop_front();
            tag = tag_q.pop_front();
            $display("[TB] %-12s jump=%0b targ=0x%0h dec=%b busy=%0b cnt0=%0d cnt1=%0d",
                     tag, hif.hwlp_jump, hif.hwlp_targ_addr, hif.hwlp_dec_cnt, busy,
                     cnt[0], cnt[1]);
            cmp({tag, ".jump"}, 32'(hif.hwlp_jump), 32'(e.jump));
            cmp({tag, ".targ"}, hif.hwlp_targ_addr, e.targ);
            cmp({tag, ".dec"},  32'(hif.hwlp_dec_cnt), 32'(e.dec));
            cmp({tag, ".busy"}, 32'(busy), 32'(e.busy));
        end
    endtask

    // One clock; the bench also plays the loop registers, decrementing the
    // counter selected by dec_cnt in any cycle where id_valid is high.
    task automatic tick();
        logic       id_s;
        logic       rst_s;
        logic [1:0] dec_s;
        id_s  = hif.id_valid;
        dec_s = hif.hwlp_dec_cnt;
        rst_s = rst_n;
        @(posedge clk);
        #1;
        if (rst_s && id_s) begin
            for (int k = 0; k < 2; k++) begin
                if (dec_s[k]) begin
                    cnt[k] = cnt[k] - 32'd1;
                    dec_events++;
                end
            end
        end
    endtask

    task automatic step(input string tag, input logic j, input logic [31:0] t,
                        input logic [1:0] d, input logic b);
        push(tag, j, t, d, b);
        tick();
        check_pop();
    endtask

    task automatic clr();
        fetch_valid  = 1'b0;
        flush        = 1'b0;
        hif.jump_ack = 1'b0;
        hif.id_valid = 1'b0;
    endtask

    initial begin
        clr();
        fetch_addr = '0;
        start_a    = '0;
        end_a      = '0;
        cnt        = '0;

        // Reset held for three cycles, then released with no fetch.
        rst_n = 1'b0;
        repeat (3) step("reset", 1'b0, 32'h0, 2'b00, 1'b0);
        rst_n = 1'b1;
        step("post_reset", 1'b0, 32'h0, 2'b00, 1'b0);

        // Redirect with late handshake.
        start_a[0] = 32'h100; end_a[0] = 32'h120; cnt[0] = 32'd3;
        fetch_addr = 32'h120; fetch_valid = 1'b1;
        step("jd_rise", 1'b1, 32'h100, 2'b01, 1'b1);
        clr();
        step("jd_hold", 1'b1, 32'h100, 2'b01, 1'b1);
        hif.jump_ack = 1'b1;
        step("ack_to_dec", 1'b0, 32'h100, 2'b01, 1'b1);
        clr(); hif.id_valid = 1'b1;
        step("id_to_idle", 1'b0, 32'h100, 2'b00, 1'b0);
        clr();
        cmp("cnt0_after_redirect", cnt[0], 32'd2);
        cmp("dec_events_1", 32'(dec_events), 32'd1);

        // Matching address without fetch_valid does nothing.
        fetch_addr = 32'h120;
        step("no_valid", 1'b0, 32'h100, 2'b00, 1'b0);

        // Last iteration: decrement only, no redirect.
        cnt[0] = 32'd1;
        fetch_valid = 1'b1;
        step("last_dec", 1'b0, 32'h100, 2'b01, 1'b1);
        clr();
        step("last_hold", 1'b0, 32'h100, 2'b01, 1'b1);
        hif.id_valid = 1'b1;
        step("last_done", 1'b0, 32'h100, 2'b00, 1'b0);
        clr();
        cmp("cnt0_zero", cnt[0], 32'd0);
        fetch_valid = 1'b1;
        step("inactive", 1'b0, 32'h100, 2'b00, 1'b0);
        clr();

        // Two loops: outer loop end, then simultaneous ack + id_valid.
        start_a[0] = 32'h1C0; end_a[0] = 32'h200; cnt[0] = 32'd5;
        start_a[1] = 32'h280; end_a[1] = 32'h300; cnt[1] = 32'd2;
        fetch_addr = 32'h300; fetch_valid = 1'b1;
        step("loop1_jd", 1'b1, 32'h280, 2'b10, 1'b1);
        clr(); hif.jump_ack = 1'b1; hif.id_valid = 1'b1;
        step("both_done", 1'b0, 32'h280, 2'b00, 1'b0);
        clr();
        cmp("cnt1_once", cnt[1], 32'd1);
        cmp("dec_events_3", 32'(dec_events), 32'd3);

        // Inner loop: id_valid first leaves JMP, then flush drops the jump.
        fetch_addr = 32'h200; fetch_valid = 1'b1;
        step("loop0_jd", 1'b1, 32'h1C0, 2'b01, 1'b1);
        clr(); hif.id_valid = 1'b1;
        step("id_to_jmp", 1'b1, 32'h1C0, 2'b00, 1'b1);
        clr();
        cmp("cnt0_dec", cnt[0], 32'd4);
        flush = 1'b1;
        step("flush_jmp", 1'b0, 32'h1C0, 2'b00, 1'b0);
        clr();

        // Flush in JMP_DEC without id_valid: no decrement committed.
        fetch_addr = 32'h200; fetch_valid = 1'b1;
        step("loop0_jd2", 1'b1, 32'h1C0, 2'b01, 1'b1);
        clr(); flush = 1'b1;
        step("flush_jd", 1'b0, 32'h1C0, 2'b00, 1'b0);
        clr();
        cmp("cnt0_kept", cnt[0], 32'd4);

        // Flush together with id_valid in DEC: decrement counted once.
        cnt[1] = 32'd1;
        fetch_addr = 32'h300; fetch_valid = 1'b1;
        step("loop1_dec", 1'b0, 32'h1C0, 2'b10, 1'b1);
        clr(); flush = 1'b1; hif.id_valid = 1'b1;
        step("flush_id", 1'b0, 32'h1C0, 2'b00, 1'b0);
        clr();
        cmp("cnt1_flush_dec", cnt[1], 32'd0);
        step("after_flush", 1'b0, 32'h1C0, 2'b00, 1'b0);
        cmp("dec_events_5", 32'(dec_events), 32'd5);

        // Shared end address where loop0 is inactive: loop1 must own it.
        end_a[0] = 32'h300; cnt[0] = 32'd0; cnt[1] = 32'd3;
        fetch_addr = 32'h300; fetch_valid = 1'b1;
        step("gate_cnt0", 1'b1, 32'h280, 2'b10, 1'b1);
        clr(); hif.jump_ack = 1'b1;
        step("gate_ack", 1'b0, 32'h280, 2'b10, 1'b1);
        clr(); hif.id_valid = 1'b1;
        step("gate_id", 1'b0, 32'h280, 2'b00, 1'b0);
        clr();
        cmp("cnt1_gate", cnt[1], 32'd2);

        // Asynchronous reset in the middle of a pending jump.
        fetch_valid = 1'b1;
        step("pre_rst_jd", 1'b1, 32'h280, 2'b10, 1'b1);
        clr();
        rst_n = 1'b0;
        #1;
        push("async_rst", 1'b0, 32'h0, 2'b00, 1'b0);
        check_pop();
        tick();
        rst_n = 1'b1;
        step("rst_release", 1'b0, 32'h0, 2'b00, 1'b0);
        cmp("cnt1_no_dec", cnt[1], 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/riscv_hwloop_jump_ctrl.md
Name: riscv_hwloop_jump_ctrl

Overview:
- Consumer side of the hardware-loop register file.
- Watches the fetch address against the per-loop end addresses and counters.
- At the end of a loop it requests a fetch redirect to that loop's start address, and issues the one-hot decrement request back to the loop registers.
- Sits between the loop register file, the prefetch unit (redirect handshake) and the ID stage (decrement commit on instruction valid).

Parameters:
- N_REGS, 2, number of hardware-loop register sets; index 0 is the innermost loop and has highest priority.
- N_REG_BITS, $clog2(N_REGS), width of a loop index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_addr_i  in  32  address of the instruction currently being issued from fetch
- fetch_valid_i  in  1  fetch_addr_i is valid and the instruction is handed to ID this cycle
- flush_i  in  1  pipeline flush (branch/exception); kills all pending requests
- hwlp_start_addr_i  in  N_REGS x 32  loop start addresses from the loop registers
- hwlp_end_addr_i  in  N_REGS x 32  loop end addresses
- hwlp_counter_i  in  N_REGS x 32  loop counters
- jump_ack_i  in  1  prefetch has accepted the redirect
- id_valid_i  in  1  the loop-end instruction leaves ID (the loop registers' valid_i)
- hwlp_jump_o  out  1  redirect request to prefetch
- hwlp_targ_addr_o  out  32  redirect target
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement request to the loop registers
- hwlp_busy_o  out  1  a jump or decrement is pending; detection is blocked

Behaviour:
- Reset: state IDLE, all outputs 0, target register 0.
- Detection (combinational, only in IDLE, with fetch_valid_i=1 and flush_i=0):
  - match[k] = (fetch_addr_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 0).
  - owner = lowest k with match[k]=1.
  - No match: no action.
- Latching at the clock edge when an owner exists:
  - dec_q <= onehot(owner).
  - If counter[owner] > 1 (unsigned 32-bit compare): targ_q <= start[owner], go to JMP_DEC.
  - If counter[owner] == 1 (last iteration, fall-through, no redirect): go to DEC.
- Latency: hwlp_jump_o and hwlp_dec_cnt_o rise 1 cycle after the matching fetch; both are driven from registers.
- States and outputs:
  - IDLE: no outputs.
  - JMP_DEC: jump_o=1, dec_cnt_o=dec_q.
  - JMP: jump_o=1.
  - DEC: dec_cnt_o=dec_q.
  - hwlp_targ_addr_o = targ_q; it is held stable while jump_o=1.
  - hwlp_busy_o = (state != IDLE).
- Transitions from JMP_DEC:
  - jump_ack_i && id_valid_i -> IDLE
  - jump_ack_i only -> DEC
  - id_valid_i only -> JMP
- Transitions from JMP and DEC:
  - JMP: jump_ack_i -> IDLE.
  - DEC: id_valid_i -> IDLE.
- Handshake: jump_o stays asserted until the cycle jump_ack_i=1 (inclusive). dec_cnt_o stays asserted until the cycle id_valid_i=1 (inclusive); the loop registers decrement in exactly that cycle.
- Exactly one decrement per loop end. dec_cnt_o is never multi-hot.
- A new detection is possible in the cycle after returning to IDLE, so counters are always read post-decrement.
- flush_i has priority over everything:
  - Next state is IDLE, outputs drop next cycle, and no decrement is committed unless id_valid_i is high in the same cycle.
  - If id_valid_i is also high that cycle, the decrement is committed in that cycle.
- Reset mid-operation: asynchronous return to the reset values; pending requests are lost.
- Counter value 0 means the loop is inactive and is never matched.
- Nested loops sharing an end address are unsupported (software rule). A simulation-only assertion flags multiple matches with counter != 0.
- Simulation-only assertions:
  - jump_o and targ_o stable while unacknowledged.
  - $onehot0(dec_cnt_o).

Decomposition:
- Shared package riscv_hwloop_pkg:
  - state enum hwlp_ctrl_state_e {IDLE, JMP_DEC, JMP, DEC}
  - HWLP_N_REGS default constant
  - typedef hwlp_addr_t (32 bit)
- One natural sub-module, riscv_hwloop_match: per-loop end-address compare plus priority encoder producing owner one-hot, owner index, and the owner counter>1 flag.
- The FSM and output registers stay in the top module.

Test Plan:
- Reset only (rst_n=0 for 3 cycles, then released with no fetch): outputs stay all 0 and hwlp_busy_o=0.
- Redirect with late handshake:
  - Stimulus: start[0]=0x100, end[0]=0x120, cnt[0]=3, fetch 0x120; jump_ack_i 2 cycles later, id_valid_i 3 cycles later.
  - Response: jump_o=1 with targ=0x100 from cycle+1 until the ack cycle; dec_cnt_o=2'b01 until the id_valid cycle; then IDLE.
- Last iteration: cnt[0]=1, fetch 0x120 -> no jump_o; dec_cnt_o=01 until id_valid_i; regs counter reaches 0; a second fetch of 0x120 gives no match.
- Priority between loops: loop0 end=0x200 cnt=5, loop1 end=0x300 cnt=2; fetch 0x300 -> targ=start[1], dec_cnt_o=10; fetch 0x200 -> dec_cnt_o=01.
- Simultaneous completion: in JMP_DEC, jump_ack_i and id_valid_i asserted in the same cycle -> IDLE next cycle; exactly one decrement observed at the regs.
- Flush:
  - flush_i asserted in JMP state -> jump_o low next cycle, no ack needed.
  - flush_i together with id_valid_i in DEC state -> decrement counted once, then IDLE.
